// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: first-word-fall-through
// FIFO with valid/ready read port, occupancy status and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned BYTESIZES = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic [BYTESIZES-1:0]         rx_data,
    input  logic                         rx_valid,
    input  logic                         rd_ready,
    input  logic                         clear,
    output logic [BYTESIZES-1:0]         rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [BYTESIZES-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // Status is derived from the registered count, so overflow detection
    // sees the full flag as it stood at the start of the cycle.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        rd_valid = !empty;
        count    = count_q;
        overflow = overflow_q;
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];

        pop  = rd_valid && rd_ready && !clear;
        push = rx_valid && (!full || pop) && !clear;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (rx_valid && !push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a
// negedge monitor checks every accepted read against the queue.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clock = 1'b0;
    logic       nreset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_ready;
    logic       clear;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    uart_rx_fifo #(.BYTESIZES(8), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .nreset   (nreset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_ready (rd_ready),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         mcnt = 0;
    logic       movf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: a read handshake completes on the coming edge.
    always @(negedge clock) begin
        if (nreset === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1 && clear === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%0h expected no data", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e});
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        logic mpop, mpush;
        rx_valid = v;
        rx_data  = d;
        rd_ready = r;
        clear    = c;
        if (c) begin
            exp_q.delete();
            mcnt = 0;
            movf = 1'b0;
        end else begin
            mpop  = r && (mcnt != 0);
            mpush = v && ((mcnt < DEPTH) || mpop);
            if (mpush) exp_q.push_back(d);
            if (v && !mpush) movf = 1'b1;
            mcnt = mcnt + int'(mpush) - int'(mpop);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic status(input string tag);
        chk({tag, "_count"},    {27'd0, count},    mcnt);
        chk({tag, "_empty"},    {31'd0, empty},    {31'd0, mcnt == 0});
        chk({tag, "_full"},     {31'd0, full},     {31'd0, mcnt == DEPTH});
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, {31'd0, mcnt != 0});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, movf});
        if (exp_q.size() == 0) chk({tag, "_rd_data0"}, {24'd0, rd_data}, 32'd0);
        else                   chk({tag, "_head"},     {24'd0, rd_data}, {24'd0, exp_q[0]});
    endtask

    task automatic async_reset();
        #3 nreset = 1'b0;
        exp_q.delete();
        mcnt = 0;
        movf = 1'b0;
        #1;
        chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_count",    {27'd0, count},    32'd0);
        chk("async_rd_data",  {24'd0, rd_data},  32'd0);
        rx_valid = 1'b0;
        @(posedge clock);
        #1 nreset = 1'b1;
    endtask

    initial begin
        nreset   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rd_ready = 1'b0;
        clear    = 1'b0;
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;

        // 1: reset then idle
        status("reset");
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        status("idle");

        // 2: single byte, then rd_ready while empty does nothing
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        status("one");
        chk("one_data", {24'd0, rd_data}, 32'h0000_00A5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        status("one_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        status("pop_empty");

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        status("fill");
        chk("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        status("ovf");
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        status("drain");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        status("clr");

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        status("full_pp");
        chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        status("full_pp_drain");

        // 5: steady occupancy of 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'(8'h83 + k), 1'b1, 1'b0);
            chk("wrap_count", {27'd0, count}, 32'd3);
        end
        status("wrap");
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        status("wrap_drain");

        // 6a: five bytes held with overflow set, clear beats a concurrent write
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        status("hold5");
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        status("clr_rx");
        chk("clr_rx_ovf", {31'd0, overflow}, 32'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        status("after_clr");
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 6b: reset pulsed mid-burst
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'hD1;
        async_reset();
        status("rst_mid");
        step(1'b1, 8'h42, 1'b0, 1'b0);
        status("after_rst");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        status("end");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
